// File: rtl/ysyx_25040101_imem_resp.sv
// Instruction-memory responder for the IFU fetch port.
// Word-addressed SRAM model with a fixed access latency, valid/ready
// handshakes on request and response, a side preload port, and error
// responses for misaligned or out-of-range fetches.
module ysyx_25040101_imem_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] ERR_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_inst_o,
    output logic                  rsp_err_o,
    input  logic                  load_wen_i,
    input  logic [DEPTH_LOG2-1:0] load_addr_i,
    input  logic [31:0]           load_data_i
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    // Byte span of the array; 33 bits so the compare never wraps.
    localparam logic [32:0] SPAN = 33'(64'd4 << DEPTH_LOG2);

    // The latency counter is 4 bits wide, and the address slice needs a sane depth.
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("ysyx_25040101_imem_resp: LATENCY must be within 1..15");
        end
        if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 30) begin : g_bad_depth
            $error("ysyx_25040101_imem_resp: DEPTH_LOG2 must be within 1..30");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [31:0]             addr_q;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             inst_q;
    logic                    err_q;

    logic                    accept;
    logic                    do_read;
    logic [31:0]             rd_addr;
    logic [31:0]             rd_off;
    logic                    rd_err;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [31:0]             rd_word;

    assign accept = req_valid_i & req_ready_o;

    // With LATENCY=1 the read happens in the accept cycle itself, so the
    // live request address is used while idle; otherwise the latched one.
    always_comb begin
        rd_addr = (state == IDLE) ? req_addr_i : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_err  = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
        rd_idx  = rd_off[DEPTH_LOG2+1:2];
        rd_word = (load_wen_i && (load_addr_i == rd_idx)) ? load_data_i : mem[rd_idx];
        do_read = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT/RESP on accept, WAIT -> RESP on the read cycle, RESP -> IDLE on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        req_ready_o = (state == IDLE);
        rsp_valid_o = (state == RESP);
    end

    // Latch the fetch address and load the latency down-counter on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'd0;
            addr_q <= 32'd0;
        end else if (accept) begin
            cnt    <= 4'(LATENCY - 1);
            addr_q <= req_addr_i;
        end else if (state == WAIT) begin
            cnt    <= cnt - 4'd1;
        end
    end

    // Response register: filled once per transaction and held until the next read, never cleared by handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (do_read) begin
            inst_q <= rd_err ? ERR_INST : rd_word;
            err_q  <= rd_err;
        end
    end

    // Preload port writes in every state, including while reset is held; the array is never cleared.
    always_ff @(posedge clk) begin
        if (load_wen_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    assign rsp_inst_o = inst_q;
    assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_ysyx_25040101_imem_resp.sv
// Bench for ysyx_25040101_imem_resp: a LATENCY=2 instance carries the directed
// and random fetches, a LATENCY=1 instance covers the single-cycle path and
// back-to-back throughput. Expected words come from a word-array model of memory.
module tb_ysyx_25040101_imem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] ERR   = 32'h0000_0013;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic        rsp_err;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [31:0] req_addr1 = 32'd0;
    logic        rsp_valid1;
    logic        rsp_ready1 = 1'b1;
    logic [31:0] rsp_inst1;
    logic        rsp_err1;

    logic        load_wen = 1'b0;
    logic [9:0]  load_addr = 10'd0;
    logic [31:0] load_data = 32'd0;

    logic [31:0] ref_mem [DEPTH];
    int unsigned n_checks = 0;
    int unsigned n_fails = 0;

    ysyx_25040101_imem_resp #(
        .DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2), .ERR_INST(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_inst_o(rsp_inst), .rsp_err_o(rsp_err),
        .load_wen_i(load_wen), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    ysyx_25040101_imem_resp #(
        .DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1), .ERR_INST(ERR)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_addr_i(req_addr1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
        .rsp_inst_o(rsp_inst1), .rsp_err_o(rsp_err1),
        .load_wen_i(load_wen), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    always #5 clk = ~clk;

    // Safety net in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        load_wen  = 1'b1;
        load_addr = idx[9:0];
        load_data = data;
        ref_mem[idx] = data;
        tick();
        load_wen  = 1'b0;
    endtask

    // Memory map: word i lives at BASE + 4*i; anything misaligned or outside the 4 KiB window is an error.
    function automatic void model(input logic [31:0] a, output logic [31:0] inst, output logic err);
        logic [31:0] off;
        off = a - BASE;
        if ((a % 4) != 0 || off >= 32'd4096) begin
            inst = ERR;
            err  = 1'b1;
        end else begin
            inst = ref_mem[off / 4];
            err  = 1'b0;
        end
    endfunction

    // One complete fetch on the LATENCY=2 instance with 'stall' cycles of back-pressure.
    task automatic applyStimulus(input logic [31:0] addr, input int stall);
        logic [31:0] exp_inst;
        logic        exp_err;
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = (stall == 0);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom();
        checkOutput("wait_ready", 32'(req_ready), 32'd0);
        checkOutput("wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        model(addr, exp_inst, exp_err);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_ready_low", 32'(req_ready), 32'd0);
        checkOutput("rsp_inst", rsp_inst, exp_inst);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_inst", rsp_inst, exp_inst);
            checkOutput("hold_err", 32'(rsp_err), 32'(exp_err));
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("after_valid", 32'(rsp_valid), 32'd0);
        checkOutput("after_ready", 32'(req_ready), 32'd1);
        checkOutput("after_inst_kept", rsp_inst, exp_inst);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] e_inst;
        logic        e_err;
        int          kind;

        $display("[TB] start");

        // Preload while reset is held; load port must work during reset.
        for (int i = 0; i < 64; i++) preload(i, $urandom());
        preload(1023, $urandom());
        preload(0, 32'h0050_0093);
        preload(1, 32'h0010_8113);
        rst = 1'b0;

        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_inst", rsp_inst, 32'd0);
        checkOutput("reset_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_ready1", 32'(req_ready1), 32'd1);
        checkOutput("reset_valid1", 32'(rsp_valid1), 32'd0);

        // Basic fetches, back-pressure, errors and the window boundaries.
        applyStimulus(BASE, 0);
        checkOutput("first_word", rsp_inst, 32'h0050_0093);
        applyStimulus(BASE + 32'd4, 5);
        checkOutput("second_word", rsp_inst, 32'h0010_8113);
        applyStimulus(BASE + 32'd2, 0);
        applyStimulus(BASE + 32'h1000, 0);
        applyStimulus(BASE + 32'hFFC, 1);
        applyStimulus(BASE - 32'd4, 0);

        // Load during WAIT is visible; load during RESP is not.
        req_valid = 1'b1;
        req_addr  = BASE;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        load_wen = 1'b1; load_addr = 10'd0; load_data = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
        tick();
        load_wen = 1'b0;
        checkOutput("wait_load_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wait_load_inst", rsp_inst, 32'hDEAD_BEEF);
        load_wen = 1'b1; load_addr = 10'd0; load_data = 32'h1234_5678; ref_mem[0] = 32'h1234_5678;
        tick();
        load_wen = 1'b0;
        checkOutput("resp_load_inst", rsp_inst, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("resp_load_done", 32'(rsp_valid), 32'd0);
        applyStimulus(BASE, 0);

        // Reset during WAIT drops the transaction; memory survives.
        req_valid = 1'b1;
        req_addr  = BASE + 32'd4;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_inst", rsp_inst, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        applyStimulus(BASE + 32'd4, 0);

        // LATENCY=1 instance: single fetch then back-to-back at one accept per 2 cycles.
        checkOutput("l1_idle_ready", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1;
        req_addr1  = BASE + 32'd4;
        tick();
        req_valid1 = 1'b0;
        checkOutput("l1_valid", 32'(rsp_valid1), 32'd1);
        checkOutput("l1_inst", rsp_inst1, ref_mem[1]);
        checkOutput("l1_err", 32'(rsp_err1), 32'd0);
        tick();
        checkOutput("l1_after_valid", 32'(rsp_valid1), 32'd0);
        checkOutput("l1_after_ready", 32'(req_ready1), 32'd1);
        e_inst = 32'd0;
        e_err  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            a = (c == 6) ? (BASE + 32'd1) : (BASE + 32'(4 * (c + 2)));
            req_valid1 = 1'b1;
            req_addr1  = a;
            checkOutput("b2b_ready", 32'(req_ready1), 32'((c % 2) == 0));
            checkOutput("b2b_valid", 32'(rsp_valid1), 32'((c % 2) == 1));
            if ((c % 2) == 1) begin
                checkOutput("b2b_inst", rsp_inst1, e_inst);
                checkOutput("b2b_err", 32'(rsp_err1), 32'(e_err));
            end else begin
                model(a, e_inst, e_err);
            end
            tick();
        end
        req_valid1 = 1'b0;
        checkOutput("b2b_end_valid", 32'(rsp_valid1), 32'd0);

        // Random fetches with random back-pressure and occasional idle reloads.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 63), $urandom());
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, 63));
                6:                a = BASE + 32'(4 * 1023);
                7:                a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                8:                a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 1000));
                default:          a = 32'($urandom_range(0, 32'h7FFF_FFFF));
            endcase
            applyStimulus(a, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
